// File: rtl/servo_pkg.sv
// Shared servo timing defaults and step-request decoding for the servo_pwm
// block and the debouncer-driven top level.
package servo_pkg;

  localparam int unsigned DEF_PERIOD_US = 20000;
  localparam int unsigned DEF_MIN_US    = 1000;
  localparam int unsigned DEF_MAX_US    = 2000;
  localparam int unsigned DEF_CENTER_US = 1500;
  localparam int unsigned DEF_STEP_US   = 10;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DN,
    STEP_CENTER
  } step_e;

  // Centre wins over steps; opposing steps in the same clock cancel.
  function automatic step_e decode_step(input logic up, input logic dn, input logic ctr);
    if (ctr)
      return STEP_CENTER;
    if (up && !dn)
      return STEP_UP;
    if (dn && !up)
      return STEP_DN;
    return STEP_HOLD;
  endfunction

endpackage

// File: rtl/servo_tick.sv
// Microsecond prescaler: one-clock us_tick every CLK_HZ/1000000 clocks
// (every clock when the divisor is 1).
module servo_tick #(
  parameter int unsigned CLK_HZ = 25000000
) (
  input  logic clk,
  input  logic resetn,
  output logic us_tick
);

  localparam int unsigned   DIV  = CLK_HZ / 1000000;
  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign us_tick = (cnt == LAST);

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM generator: step/centre requests adjust a target width that is
// latched at each frame start and driven out as a registered pulse.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25000000,
  parameter int unsigned PERIOD_US = DEF_PERIOD_US,
  parameter int unsigned MIN_US    = DEF_MIN_US,
  parameter int unsigned MAX_US    = DEF_MAX_US,
  parameter int unsigned CENTER_US = DEF_CENTER_US,
  parameter int unsigned STEP_US   = DEF_STEP_US
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trans_up,
  input  logic        trans_dn,
  input  logic        center,
  output logic        pwm,
  output logic [10:0] width_us,
  output logic        at_min,
  output logic        at_max,
  output logic        frame
);

  localparam logic [14:0] PERIOD_LAST = 15'(PERIOD_US - 1);
  localparam logic [10:0] MIN_T       = 11'(MIN_US);
  localparam logic [10:0] MAX_T       = 11'(MAX_US);
  localparam logic [10:0] CENTER_T    = 11'(CENTER_US);
  localparam logic [10:0] STEP_T      = 11'(STEP_US);
  localparam logic [11:0] UP_CEIL     = 12'(MAX_US);
  localparam logic [11:0] DN_FLOOR    = 12'(MIN_US + STEP_US);

  logic        started;
  logic        tick_resetn;
  logic        us_tick;
  logic        frame_start;
  logic [14:0] period_us;
  logic [10:0] target;
  logic [10:0] target_nx;
  logic [10:0] active_width;
  logic [11:0] up_sum;

  // Prescaler stays cleared through the first post-reset clock so that the
  // opening frame has period_us=0 for a full microsecond like every other.
  assign tick_resetn = resetn & started;

  servo_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .resetn  (tick_resetn),
    .us_tick (us_tick)
  );

  assign up_sum = {1'b0, target} + {1'b0, STEP_T};

  always_comb begin
    target_nx = target;
    case (decode_step(trans_up, trans_dn, center))
      STEP_CENTER: target_nx = CENTER_T;
      STEP_UP:     target_nx = (up_sum > UP_CEIL) ? MAX_T : up_sum[10:0];
      STEP_DN:     target_nx = ({1'b0, target} < DN_FLOOR) ? MIN_T : target - STEP_T;
      default:     target_nx = target;
    endcase
  end

  assign frame_start = !started || (us_tick && period_us == PERIOD_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      started      <= 1'b0;
      target       <= CENTER_T;
      active_width <= CENTER_T;
      period_us    <= '0;
      frame        <= 1'b0;
      pwm          <= 1'b0;
    end else begin
      started <= 1'b1;
      target  <= target_nx;
      frame   <= frame_start;
      pwm     <= started && (period_us < {4'b0, active_width});
      if (frame_start) begin
        active_width <= target;
        period_us    <= '0;
      end else if (us_tick) begin
        period_us <= period_us + 15'd1;
      end
    end
  end

  assign width_us = target;
  assign at_min   = (target == MIN_T);
  assign at_max   = (target == MAX_T);

endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter CLK_HZ, default 25000000: system clock frequency in Hz; SHALL be an integer multiple of 1000000.
REQ-002 Parameter PERIOD_US, default 20000: PWM frame length in microseconds.
REQ-003 Parameter MIN_US, default 1000: minimum pulse width in microseconds.
REQ-004 Parameter MAX_US, default 2000: maximum pulse width in microseconds.
REQ-005 Parameter CENTER_US, default 1500: reset and centre pulse width in microseconds.
REQ-006 Parameter STEP_US, default 10: width change per step request in microseconds.
REQ-007 clk  input  1: single system clock; all logic is on its rising edge.
REQ-008 resetn  input  1: reset, synchronous and active-low.
REQ-009 trans_up  input  1: one-clock step-up request, driven by a debouncer transition output.
REQ-010 trans_dn  input  1: one-clock step-down request, driven by a debouncer transition output.
REQ-011 center  input  1: one-clock request to return the target width to CENTER_US.
REQ-012 pwm  output  1: servo control pulse, registered.
REQ-013 width_us  output  11: current target pulse width in microseconds.
REQ-014 at_min, at_max  output  1 each: target equals MIN_US or MAX_US respectively.
REQ-015 frame  output  1: one-clock pulse at the start of each PWM frame.

Function
REQ-016 A prescaler SHALL produce a one-clock us_tick every CLK_HZ/1000000 clocks; a divisor of 1 SHALL assert us_tick every clock.
REQ-017 The 15-bit period_us counter SHALL advance on us_tick, count 0..PERIOD_US-1, and wrap to 0.
REQ-018 On the clock where period_us wraps to 0, or the first clock after reset release, active_width SHALL load from target and frame SHALL assert for exactly one clock.
REQ-019 pwm SHALL be registered as (period_us < active_width), giving one clock of latency relative to period_us.
REQ-020 The high time of pwm SHALL be exactly active_width microseconds per frame, and the frame SHALL last exactly PERIOD_US microseconds.
REQ-021 trans_up alone SHALL set target to min(target+STEP_US, MAX_US); the addition SHALL be at least 12 bits wide so it cannot overflow.
REQ-022 trans_dn alone SHALL set target to max(target-STEP_US, MIN_US); the result SHALL never underflow.
REQ-023 Simultaneous trans_up and trans_dn SHALL leave target unchanged.
REQ-024 center SHALL take priority over trans_up and trans_dn and set target to CENTER_US.
REQ-025 A target change mid-frame SHALL NOT alter the current pulse; it SHALL take effect at the next frame start.
REQ-026 width_us SHALL equal target, and at_min and at_max SHALL be combinational compares on target.
REQ-027 Requests arriving on every consecutive clock SHALL each be applied; none SHALL be dropped.

Reset
REQ-028 While resetn is low at a clock edge: pwm=0, frame=0, target=CENTER_US, active_width=CENTER_US, prescaler=0, period_us=0.
REQ-029 Reset asserted mid-pulse SHALL force pwm low on the next edge; after release, a full new frame SHALL start at period_us=0.

Structure
REQ-030 Default timing constants (PERIOD_US, MIN_US, MAX_US, CENTER_US, STEP_US) SHALL live in the shared package servo_pkg, for reuse by the debouncer-driven top level.
REQ-031 The microsecond prescaler SHALL be the sub-module servo_tick (parameter CLK_HZ; ports clk, resetn, us_tick).
REQ-032 The design SHALL contain no other sub-modules and no second clock domain.

Verification (CLK_HZ=1000000, PERIOD_US=100, MIN=10, MAX=20, CENTER=15, STEP=4 unless noted)
REQ-033 Reset release, no requests -> frame pulses every 100 clocks; pwm is high for 15 clocks per frame; width_us=15.
REQ-034 Three trans_up pulses -> width_us goes 19, then 20 with at_max=1, then stays 20; the next frame's pwm high time is 20.
REQ-035 Four trans_dn pulses from 15 -> width_us goes 11, 10, 10, 10 with at_min=1; trans_up and trans_dn in the same clock -> no change.
REQ-036 trans_up at period_us=5 of a 15-wide frame -> the current pulse stays 15; the next frame's pulse is 19.
REQ-037 center together with trans_up while width_us=20 -> width_us=15.
REQ-038 CLK_HZ=4000000 -> us_tick every 4 clocks; with defaults the frame is 80000 clocks and the pwm high time is 6000 clocks; resetn low mid-pulse -> pwm=0 on the next edge.
